psum_ctrl: RTL and testbench



---
 rtl/psum_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_psum_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psum_ctrl
// Purpose  : Sequencer for the ping-pong partial-sum buffer (init, accumulate,
//            role swap, drain with zero refill, flush).
// Revision : 1.0
// ============================================================================
module psum_ctrl #(
    parameter int DEPTH    = 61,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_row_len,
    input  logic [CNT_W-1:0] cfg_num_pass,
    input  logic [CNT_W-1:0] cfg_num_rows,
    input  logic             pe_valid,
    output logic             pe_ready,
    input  logic             ext_stall,
    output logic             p_init,
    output logic             p_valid_data,
    output logic             p_write_zero,
    output logic             odd_cnt,
    output logic             psum_stall,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_INIT  = 3'd1;
    localparam logic [2:0] c_SWAP  = 3'd2;
    localparam logic [2:0] c_RUN   = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_FLUSH = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    localparam logic [1:0] c_D_WAIT = 2'd0;
    localparam logic [1:0] c_D_TOG  = 2'd1;
    localparam logic [1:0] c_D_WZ   = 2'd2;

    localparam logic [CNT_W-1:0] c_MAX_LEN = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_MIN_LEN = CNT_W'(4);
    localparam logic [CNT_W-1:0] c_LAT     = CNT_W'(PIPE_LAT);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [1:0]       r_dphase;
    logic [CNT_W-1:0] r_row_len;
    logic [CNT_W-1:0] r_num_pass;
    logic [CNT_W-1:0] r_num_rows;
    logic [CNT_W-1:0] r_col_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_row_cnt;
    logic             r_odd;

    logic w_cfg_ok;
    logic w_stall;
    logic w_adv;
    logic w_accept;
    logic w_col_last;
    logic w_pass_last;
    logic w_row_more;
    logic w_lat_last;
    logic w_flush_last;

    assign w_cfg_ok = (cfg_row_len >= c_MIN_LEN) && (cfg_row_len <= c_MAX_LEN) &&
                      (cfg_num_pass != '0) && (cfg_num_rows != '0);

    assign w_stall      = ext_stall | ((r_state == c_RUN) & ~pe_valid);
    assign w_adv        = ~w_stall;
    assign w_accept     = (r_state == c_RUN) & w_adv;
    assign w_col_last   = (r_col_cnt == r_row_len - c_ONE);
    assign w_pass_last  = (r_pass_cnt == r_num_pass - c_ONE);
    assign w_row_more   = ((r_row_cnt + c_ONE) < r_num_rows);
    assign w_lat_last   = (r_col_cnt == c_LAT - c_ONE);
    assign w_flush_last = (r_col_cnt == c_LAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start && w_cfg_ok) w_next_state = c_INIT;
            c_INIT:  if (w_adv && w_col_last) w_next_state = c_SWAP;
            c_SWAP:  if (w_adv) w_next_state = c_RUN;
            c_RUN: begin
                if (w_adv && w_col_last && w_pass_last) begin
                    w_next_state = w_row_more ? c_SWAP : c_DRAIN;
                end
            end
            c_DRAIN: if (w_adv && (r_dphase == c_D_WZ) && w_col_last) w_next_state = c_FLUSH;
            c_FLUSH: if (w_adv && w_flush_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Counters, shadow config and FIFO role bit; odd_cnt survives between jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dphase   <= c_D_WAIT;
            r_row_len  <= '0;
            r_num_pass <= '0;
            r_num_rows <= '0;
            r_col_cnt  <= '0;
            r_pass_cnt <= '0;
            r_row_cnt  <= '0;
            r_odd      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && w_cfg_ok) begin
                        r_row_len  <= cfg_row_len;
                        r_num_pass <= cfg_num_pass;
                        r_num_rows <= cfg_num_rows;
                        r_col_cnt  <= '0;
                        r_pass_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_dphase   <= c_D_WAIT;
                    end
                end
                c_INIT: begin
                    if (w_adv) r_col_cnt <= w_col_last ? '0 : r_col_cnt + c_ONE;
                end
                c_SWAP: begin
                    if (w_adv) begin
                        r_odd      <= ~r_odd;
                        r_col_cnt  <= '0;
                        r_pass_cnt <= '0;
                    end
                end
                c_RUN: begin
                    if (w_adv) begin
                        if (w_col_last) begin
                            r_col_cnt <= '0;
                            if (w_pass_last) begin
                                r_pass_cnt <= '0;
                                r_row_cnt  <= r_row_cnt + c_ONE;
                                r_dphase   <= c_D_WAIT;
                            end else begin
                                r_pass_cnt <= r_pass_cnt + c_ONE;
                            end
                        end else begin
                            r_col_cnt <= r_col_cnt + c_ONE;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_adv) begin
                        case (r_dphase)
                            c_D_WAIT: begin
                                if (w_lat_last) begin
                                    r_col_cnt <= '0;
                                    r_dphase  <= c_D_TOG;
                                end else begin
                                    r_col_cnt <= r_col_cnt + c_ONE;
                                end
                            end
                            c_D_TOG: begin
                                r_odd    <= ~r_odd;
                                r_dphase <= c_D_WZ;
                            end
                            default: r_col_cnt <= w_col_last ? '0 : r_col_cnt + c_ONE;
                        endcase
                    end
                end
                c_FLUSH: begin
                    if (w_adv) r_col_cnt <= r_col_cnt + c_ONE;
                end
                default: r_col_cnt <= '0;
            endcase
        end
    end

    // Pass 0 of every row after the first drains the previous row's FIFO.
    always_comb begin
        pe_ready     = (r_state == c_RUN) & ~ext_stall;
        p_init       = (r_state == c_INIT);
        p_valid_data = w_accept;
        p_write_zero = (w_accept && (r_pass_cnt == '0) && (r_row_cnt != '0)) ||
                       ((r_state == c_DRAIN) && (r_dphase == c_D_WZ));
        odd_cnt      = r_odd;
        psum_stall   = w_stall;
        busy         = (r_state != c_IDLE);
        done         = (r_state == c_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_ctrl
// Purpose  : Scoreboard bench for psum_ctrl: expected control-event stream is
//            queued at job start and popped as the DUT emits events.
// Revision : 1.0
// ============================================================================
module tb_psum_ctrl;

    localparam int CNT_W  = 8;
    localparam int E_INIT = 1;
    localparam int E_TOG  = 2;
    localparam int E_BEAT = 3;
    localparam int E_BWZ  = 4;
    localparam int E_WZ   = 5;
    localparam int E_DONE = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_row_len;
    logic [CNT_W-1:0] cfg_num_pass;
    logic [CNT_W-1:0] cfg_num_rows;
    logic             pe_valid;
    logic             pe_ready;
    logic             ext_stall;
    logic             p_init;
    logic             p_valid_data;
    logic             p_write_zero;
    logic             odd_cnt;
    logic             psum_stall;
    logic             busy;
    logic             done;

    int q[$];
    int n_cmp;
    int n_err;
    int ncyc;
    int gcyc;
    int t_busy;
    bit mon_en;
    bit gap_mode;
    bit lat_check;
    logic prev_odd;
    logic prev_busy;

    psum_ctrl #(.DEPTH(61), .CNT_W(CNT_W), .PIPE_LAT(3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_row_len  (cfg_row_len),
        .cfg_num_pass (cfg_num_pass),
        .cfg_num_rows (cfg_num_rows),
        .pe_valid     (pe_valid),
        .pe_ready     (pe_ready),
        .ext_stall    (ext_stall),
        .p_init       (p_init),
        .p_valid_data (p_valid_data),
        .p_write_zero (p_write_zero),
        .odd_cnt      (odd_cnt),
        .psum_stall   (psum_stall),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input int code);
        int exp;
        if (q.size() == 0) begin
            chk("sb_extra", code, 0);
        end else begin
            exp = q.pop_front();
            chk("sb_event", code, exp);
        end
    endtask

    task automatic push_job(input int rl, input int np, input int nr);
        repeat (rl) q.push_back(E_INIT);
        for (int r = 0; r < nr; r++) begin
            q.push_back(E_TOG);
            for (int p = 0; p < np; p++)
                for (int c = 0; c < rl; c++)
                    q.push_back((p == 0 && r >= 1) ? E_BWZ : E_BEAT);
        end
        q.push_back(E_TOG);
        repeat (rl) q.push_back(E_WZ);
        q.push_back(E_DONE);
    endtask

    task automatic start_job(input int rl, input int np, input int nr);
        @(posedge clk); #1;
        cfg_row_len  = CNT_W'(rl);
        cfg_num_pass = CNT_W'(np);
        cfg_num_rows = CNT_W'(nr);
        start        = 1'b1;
        push_job(rl, np, nr);
        @(posedge clk); #1;
        start        = 1'b0;
        cfg_row_len  = CNT_W'($urandom_range(0, 255));
        cfg_num_pass = CNT_W'($urandom_range(0, 255));
        cfg_num_rows = CNT_W'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("job_timeout", q.size(), 0);
        @(negedge clk);
        chk("idle_after_job", busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_pe_ready"}, pe_ready, 0);
        chk({tag, "_p_init"}, p_init, 0);
        chk({tag, "_p_valid"}, p_valid_data, 0);
        chk({tag, "_p_wz"}, p_write_zero, 0);
        chk({tag, "_odd"}, odd_cnt, 0);
        chk({tag, "_stall"}, psum_stall, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic try_bad(input int rl, input int np, input int nr);
        @(posedge clk); #1;
        cfg_row_len  = CNT_W'(rl);
        cfg_num_pass = CNT_W'(np);
        cfg_num_rows = CNT_W'(nr);
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bad_cfg_busy", busy, 0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        gcyc++;
        pe_valid = gap_mode ? (gcyc % 3 != 0) : 1'b1;
    end

    // Event monitor: every unstalled control cycle, role toggle and done pulse.
    always @(negedge clk) begin
        ncyc++;
        if (mon_en && !rst) begin
            if (busy && !prev_busy) t_busy = ncyc;
            if (odd_cnt != prev_odd) sb_pop(E_TOG);
            if (!psum_stall) begin
                if (p_init) begin
                    sb_pop(E_INIT);
                    chk("init_exclusive", {31'd0, p_valid_data | p_write_zero}, 0);
                end else if (p_valid_data) begin
                    sb_pop(p_write_zero ? E_BWZ : E_BEAT);
                end else if (p_write_zero) begin
                    sb_pop(E_WZ);
                end
            end else begin
                chk("stalled_no_valid", p_valid_data, 0);
            end
            if (done) begin
                sb_pop(E_DONE);
                if (lat_check) chk("done_latency", ncyc - t_busy, 21);
            end
            if (gap_mode && pe_ready) chk("stall_mirror", psum_stall, !pe_valid);
        end
        prev_odd  = odd_cnt;
        prev_busy = busy;
    end

    initial begin
        int n;
        clk = 0; rst = 1; start = 0; ext_stall = 0;
        cfg_row_len = '0; cfg_num_pass = '0; cfg_num_rows = '0;
        n_cmp = 0; n_err = 0; ncyc = 0; gcyc = 0; t_busy = 0;
        mon_en = 0; gap_mode = 0; lat_check = 0;
        prev_odd = 0; prev_busy = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 mon_en = 1;

        // Minimal job with end-to-end latency check
        lat_check = 1;
        start_job(4, 1, 1);
        wait_done(200);
        lat_check = 0;

        // Two rows, three passes; a mid-run start must be ignored
        start_job(8, 3, 2);
        repeat (20) @(posedge clk);
        #1;
        cfg_row_len = 8'd5; cfg_num_pass = 8'd1; cfg_num_rows = 8'd1; start = 1;
        @(posedge clk); #1 start = 0;
        wait_done(500);

        // Same job with a PE bubble every third cycle
        gap_mode = 1;
        start_job(8, 3, 2);
        wait_done(800);
        gap_mode = 0;

        // Backpressure in INIT and in the drain phase
        start_job(8, 1, 1);
        repeat (2) @(posedge clk);
        #1 ext_stall = 1;
        repeat (5) begin
            @(negedge clk);
            chk("init_stall_p_init", p_init, 1);
            chk("init_stall_ready", pe_ready, 0);
            chk("init_stall_psum", psum_stall, 1);
        end
        @(posedge clk); #1 ext_stall = 0;
        n = 0;
        while (!p_write_zero && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_drain", p_write_zero, 1);
        @(posedge clk); #1 ext_stall = 1;
        repeat (5) begin
            @(negedge clk);
            chk("drain_stall_wz", p_write_zero, 1);
            chk("drain_stall_valid", p_valid_data, 0);
            chk("drain_stall_ready", pe_ready, 0);
        end
        @(posedge clk); #1 ext_stall = 0;
        wait_done(300);

        // Reset in the middle of RUN aborts with no done pulse
        start_job(8, 3, 2);
        n = 0;
        while (!pe_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_run", pe_ready, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        mon_en = 0;
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_quiet("midrun_reset");
        q.delete();
        @(posedge clk); #1 mon_en = 1;
        repeat (30) @(negedge clk);
        chk("post_reset_idle", busy, 0);
        start_job(4, 1, 1);
        wait_done(200);

        // Illegal configurations never leave IDLE
        try_bad(2, 1, 1);
        try_bad(8, 0, 1);
        try_bad(8, 1, 0);
        try_bad(62, 1, 1);
        chk("sb_empty_end", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
